// File: rtl/vga_timing_generator.sv
// Raster timing stage: horizontal/vertical phase FSMs, active-region counters,
// and sync/blanking delayed one cycle to line up with the colour manager's data.
module vga_timing_generator #(
  parameter int       COUNTER_WIDTH    = 11,
  parameter int       FRONTPORCH_WIDTH = 11,
  parameter int       BACKPORCH_WIDTH  = 8,
  parameter int       DATA_WIDTH       = 12,
  parameter int       H_FP_LEN         = 16,
  parameter int       H_SYNC_LEN       = 96,
  parameter int       V_FP_LEN         = 10,
  parameter int       V_SYNC_LEN       = 2,
  parameter logic     SYNC_POL         = 1'b0,
  parameter int       RST_H_ACT        = 640,
  parameter int       RST_H_BP         = 48,
  parameter int       RST_V_ACT        = 480,
  parameter int       RST_V_BP         = 33
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic [FRONTPORCH_WIDTH-1:0] H_FrontPorch,
  input  logic [BACKPORCH_WIDTH-1:0]  H_BackPorch,
  input  logic [FRONTPORCH_WIDTH-1:0] V_FrontPorch,
  input  logic [BACKPORCH_WIDTH-1:0]  V_BackPorch,
  input  logic [DATA_WIDTH-1:0]       Data_VGA,
  output logic                        Counter_X_Valid,
  output logic [COUNTER_WIDTH-1:0]    Counter_X,
  output logic                        Counter_Y_Valid,
  output logic [COUNTER_WIDTH-1:0]    Counter_Y,
  output logic                        HSync,
  output logic                        VSync,
  output logic [DATA_WIDTH-1:0]       RGB,
  output logic                        Frame_Start
);

  // state     | meaning
  // ST_ACTIVE | visible pixels / lines
  // ST_FP     | front porch (fixed length)
  // ST_SYNC   | sync pulse (fixed length)
  // ST_BACK   | back porch (shadowed, may be zero and then skipped)
  typedef enum logic [1:0] {ST_ACTIVE, ST_FP, ST_SYNC, ST_BACK} phase_e;

  localparam logic [COUNTER_WIDTH-1:0] H_FP_LD   = COUNTER_WIDTH'(H_FP_LEN - 1);
  localparam logic [COUNTER_WIDTH-1:0] H_SYNC_LD = COUNTER_WIDTH'(H_SYNC_LEN - 1);
  localparam logic [COUNTER_WIDTH-1:0] V_FP_LD   = COUNTER_WIDTH'(V_FP_LEN - 1);
  localparam logic [COUNTER_WIDTH-1:0] V_SYNC_LD = COUNTER_WIDTH'(V_SYNC_LEN - 1);

  phase_e                   h_state_q, h_state_d, v_state_q, v_state_d;
  logic [COUNTER_WIDTH-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [COUNTER_WIDTH-1:0] x_q, x_d, y_q, y_d;
  logic [COUNTER_WIDTH-1:0] h_act_q, h_act_d, h_bp_q, h_bp_d;
  logic [COUNTER_WIDTH-1:0] v_act_q, v_act_d, v_bp_q, v_bp_d;
  logic                     run_q;
  logic                     valid_q, valid_d, fs_q, fs_d;
  logic [COUNTER_WIDTH-1:0] cx_q, cx_d, cy_q, cy_d;
  logic                     hs_q, hs_d, vs_q, vs_d, act_dly_q, act_dly_d;
  logic                     h_last, v_last, eol, eof, req_ok;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      h_state_q <= ST_ACTIVE;
      v_state_q <= ST_ACTIVE;
      h_cnt_q   <= COUNTER_WIDTH'(RST_H_ACT - 1);
      v_cnt_q   <= COUNTER_WIDTH'(RST_V_ACT - 1);
      x_q       <= '0;
      y_q       <= '0;
      h_act_q   <= COUNTER_WIDTH'(RST_H_ACT);
      h_bp_q    <= COUNTER_WIDTH'(RST_H_BP);
      v_act_q   <= COUNTER_WIDTH'(RST_V_ACT);
      v_bp_q    <= COUNTER_WIDTH'(RST_V_BP);
      run_q     <= 1'b0;
      valid_q   <= 1'b1;
      cx_q      <= '0;
      cy_q      <= '0;
      fs_q      <= 1'b0;
      hs_q      <= ~SYNC_POL;
      vs_q      <= ~SYNC_POL;
      act_dly_q <= 1'b0;
    end else begin
      h_state_q <= h_state_d;
      v_state_q <= v_state_d;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      x_q       <= x_d;
      y_q       <= y_d;
      h_act_q   <= h_act_d;
      h_bp_q    <= h_bp_d;
      v_act_q   <= v_act_d;
      v_bp_q    <= v_bp_d;
      run_q     <= 1'b1;
      valid_q   <= valid_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      fs_q      <= fs_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      act_dly_q <= act_dly_d;
    end
  end

  always_comb begin
    h_state_d = h_state_q;
    v_state_d = v_state_q;
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    x_d       = x_q;
    y_d       = y_q;
    h_act_d   = h_act_q;
    h_bp_d    = h_bp_q;
    v_act_d   = v_act_q;
    v_bp_d    = v_bp_q;
    h_last    = (h_cnt_q == '0);
    v_last    = (v_cnt_q == '0);
    eol       = h_last && ((h_state_q == ST_BACK) || (h_state_q == ST_SYNC && h_bp_q == '0));
    eof       = eol && v_last &&
                ((v_state_q == ST_BACK) || (v_state_q == ST_SYNC && v_bp_q == '0));
    req_ok    = (H_FrontPorch >= FRONTPORCH_WIDTH'(2)) && (V_FrontPorch >= FRONTPORCH_WIDTH'(2));
    // The first edge after reset release holds position (0,0) so it is shown for a full cycle
    if (run_q) begin
      if (eof && req_ok) begin
        h_act_d = COUNTER_WIDTH'(H_FrontPorch);
        h_bp_d  = COUNTER_WIDTH'(H_BackPorch);
        v_act_d = COUNTER_WIDTH'(V_FrontPorch);
        v_bp_d  = COUNTER_WIDTH'(V_BackPorch);
      end
      if (!h_last) begin
        h_cnt_d = h_cnt_q - 1'b1;
        if (h_state_q == ST_ACTIVE) x_d = x_q + 1'b1;
      end else begin
        case (h_state_q)
          ST_ACTIVE: begin h_state_d = ST_FP;   h_cnt_d = H_FP_LD;   x_d = '0; end
          ST_FP:     begin h_state_d = ST_SYNC; h_cnt_d = H_SYNC_LD; end
          ST_SYNC: begin
            if (h_bp_q == '0) begin
              h_state_d = ST_ACTIVE; h_cnt_d = h_act_d - 1'b1;
            end else begin
              h_state_d = ST_BACK;   h_cnt_d = h_bp_q - 1'b1;
            end
          end
          default:   begin h_state_d = ST_ACTIVE; h_cnt_d = h_act_d - 1'b1; end
        endcase
      end
      if (eol) begin
        if (!v_last) begin
          v_cnt_d = v_cnt_q - 1'b1;
          if (v_state_q == ST_ACTIVE) y_d = y_q + 1'b1;
        end else begin
          case (v_state_q)
            ST_ACTIVE: begin v_state_d = ST_FP;   v_cnt_d = V_FP_LD;   y_d = '0; end
            ST_FP:     begin v_state_d = ST_SYNC; v_cnt_d = V_SYNC_LD; end
            ST_SYNC: begin
              if (v_bp_q == '0) begin
                v_state_d = ST_ACTIVE; v_cnt_d = v_act_d - 1'b1;
              end else begin
                v_state_d = ST_BACK;   v_cnt_d = v_bp_q - 1'b1;
              end
            end
            default:   begin v_state_d = ST_ACTIVE; v_cnt_d = v_act_d - 1'b1; end
          endcase
        end
      end
    end
  end

  always_comb begin
    valid_d   = (h_state_d == ST_ACTIVE) && (v_state_d == ST_ACTIVE);
    cx_d      = valid_d ? x_d : '0;
    cy_d      = valid_d ? y_d : '0;
    fs_d      = valid_d && (x_d == '0) && (y_d == '0);
    hs_d      = (run_q && h_state_q == ST_SYNC) ? SYNC_POL : ~SYNC_POL;
    vs_d      = (run_q && v_state_q == ST_SYNC) ? SYNC_POL : ~SYNC_POL;
    act_dly_d = run_q && valid_q;
    RGB       = act_dly_q ? Data_VGA : '0;
  end

  assign Counter_X_Valid = valid_q;
  assign Counter_Y_Valid = valid_q;
  assign Counter_X       = cx_q;
  assign Counter_Y       = cy_q;
  assign Frame_Start     = fs_q;
  assign HSync           = hs_q;
  assign VSync           = vs_q;

endmodule
